// File: rtl/addsub_acc_pkg.sv
// Shared types and defaults for the add/subtract accumulator slice.
package addsub_acc_pkg;

  localparam int ACC_WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    OP_CLR  = 2'b00,
    OP_LOAD = 2'b01,
    OP_ADD  = 2'b10,
    OP_SUB  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_RESP = 2'b10
  } state_e;

endpackage

// File: rtl/addsub_accumulator_if.sv
// Command/result handshake bundle for addsub_accumulator.
interface addsub_accumulator_if
  import addsub_acc_pkg::*;
#(
  parameter int WIDTH = ACC_WIDTH_DEFAULT
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] acc;
  logic             flag_c;
  logic             flag_v;
  logic             flag_z;
  logic             flag_n;

  modport master (
    output in_valid, in_op, in_b, out_ready,
    input  in_ready, out_valid, acc, flag_c, flag_v, flag_z, flag_n
  );

  modport slave (
    input  in_valid, in_op, in_b, out_ready,
    output in_ready, out_valid, acc, flag_c, flag_v, flag_z, flag_n
  );
endinterface

// File: rtl/addsub_core.sv
// Combinational WIDTH-bit ripple adder/subtractor; sub inverts B and sets carry-in.
module addsub_core #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  always_comb begin : ripple
    logic carry;
    sum   = '0;
    c_msb = 1'b0;
    carry = sub;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (i == WIDTH - 1) c_msb = carry;
      sum[i] = a[i] ^ (b[i] ^ sub) ^ carry;
      carry  = (a[i] & (b[i] ^ sub)) | (carry & (a[i] ^ (b[i] ^ sub)));
    end
    cout = carry;
  end

endmodule

// File: rtl/addsub_accumulator.sv
// Accumulator stage around addsub_core: IDLE -> CALC -> RESP handshake FSM.
// Define ADDSUB_ACC_SAT_EN to saturate ADD/SUB results on signed overflow.
module addsub_accumulator
  import addsub_acc_pkg::*;
#(
  parameter int WIDTH = ACC_WIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  addsub_accumulator_if.slave bus
);

  state_e           state_q, state_d;
  op_e              op_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc_q;
  logic             c_q, v_q, z_q, n_q;

  logic [WIDTH-1:0] core_sum;
  logic             core_cout, core_cmsb, core_sub;

  logic [WIDTH-1:0] res_acc;
  logic             res_c, res_v;

  assign core_sub = (op_q == OP_SUB);

  addsub_core #(.WIDTH(WIDTH)) u_core (
    .a     (acc_q),
    .b     (b_q),
    .sub   (core_sub),
    .sum   (core_sum),
    .cout  (core_cout),
    .c_msb (core_cmsb)
  );

  always_comb begin
    res_acc = acc_q;
    res_c   = 1'b0;
    res_v   = 1'b0;
    unique case (op_q)
      OP_CLR:  res_acc = '0;
      OP_LOAD: res_acc = b_q;
      OP_ADD, OP_SUB: begin
        res_acc = core_sum;
        res_c   = core_cout;
        res_v   = core_cmsb ^ core_cout;
`ifdef ADDSUB_ACC_SAT_EN
        // Wrapped MSB set means the true result was positive, and vice versa.
        if (res_v) res_acc = core_sum[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                                               : {1'b1, {(WIDTH-1){1'b0}}};
`endif
      end
      default: res_acc = acc_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (bus.in_valid) state_d = S_CALC;
      S_CALC:  state_d = S_RESP;
      S_RESP:  if (bus.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= OP_CLR;
      b_q     <= '0;
      acc_q   <= '0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      z_q     <= 1'b1;
      n_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && bus.in_valid) begin
        op_q <= op_e'(bus.in_op);
        b_q  <= bus.in_b;
      end
      if (state_q == S_CALC) begin
        acc_q <= res_acc;
        c_q   <= res_c;
        v_q   <= res_v;
        z_q   <= (res_acc == '0);
        n_q   <= res_acc[WIDTH-1];
      end
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_RESP);
  assign bus.acc       = acc_q;
  assign bus.flag_c    = c_q;
  assign bus.flag_v    = v_q;
  assign bus.flag_z    = z_q;
  assign bus.flag_n    = n_q;

endmodule

// File: tb/tb_addsub_accumulator.sv
// Self-checking bench for addsub_accumulator: vector table, corner sequences, random vs. model.
module tb_addsub_accumulator;
  import addsub_acc_pkg::*;

  localparam int W    = 4;
  localparam int MASK = (1 << W) - 1;
  localparam int SMAX = (1 << (W - 1)) - 1;
  localparam int SMIN = -(1 << (W - 1));

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  addsub_accumulator_if #(.WIDTH(W)) bus ();
  addsub_accumulator #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;
  int m_acc, m_c, m_v;

  typedef struct {
    logic [1:0] op;
    int b, hold, eacc, ec, ev, ez, en;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int sx(input int x);
    return (x > SMAX) ? x - (1 << W) : x;
  endfunction

  function automatic void model_reset();
    m_acc = 0; m_c = 0; m_v = 0;
  endfunction

  function automatic void model_apply(input logic [1:0] op, input int b);
    int full, s;
    case (op)
      2'b00: begin m_acc = 0; m_c = 0; m_v = 0; end
      2'b01: begin m_acc = b & MASK; m_c = 0; m_v = 0; end
      default: begin
        if (op == 2'b10) begin
          full = m_acc + b;
          s    = sx(m_acc) + sx(b);
        end else begin
          full = m_acc + ((~b) & MASK) + 1;
          s    = sx(m_acc) - sx(b);
        end
        m_c   = (full >> W) & 1;
        m_v   = (s > SMAX || s < SMIN) ? 1 : 0;
        m_acc = full & MASK;
`ifdef ADDSUB_ACC_SAT_EN
        if (m_v == 1) m_acc = (s > 0) ? SMAX : (SMIN & MASK);
`endif
      end
    endcase
  endfunction

  task automatic issue(input logic [1:0] op, input int b);
    int guard = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_b     = W'(b);
    while (!bus.in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) begin
      chk("accept_timeout", 0, 1);
      bus.in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      model_apply(op, b);
    end
  endtask

  task automatic expect_result(input string nm, input int eacc, input int ec, input int ev,
                               input int ez, input int en, input int hold);
    @(negedge clk);
    chk({nm, "_calc_ovalid"}, int'(bus.out_valid), 0);
    chk({nm, "_calc_iready"}, int'(bus.in_ready), 0);
    @(negedge clk);
    chk({nm, "_ovalid"}, int'(bus.out_valid), 1);
    chk({nm, "_iready"}, int'(bus.in_ready), 0);
    chk({nm, "_acc"}, int'(bus.acc), eacc);
    chk({nm, "_c"}, int'(bus.flag_c), ec);
    chk({nm, "_v"}, int'(bus.flag_v), ev);
    chk({nm, "_z"}, int'(bus.flag_z), ez);
    chk({nm, "_n"}, int'(bus.flag_n), en);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({nm, "_hold_ovalid"}, int'(bus.out_valid), 1);
      chk({nm, "_hold_acc"}, int'(bus.acc), eacc);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    @(negedge clk);
    chk({nm, "_done_ovalid"}, int'(bus.out_valid), 0);
    chk({nm, "_done_iready"}, int'(bus.in_ready), 1);
  endtask

  task automatic expect_model(input string nm, input int hold);
    expect_result(nm, m_acc, m_c, m_v, (m_acc == 0) ? 1 : 0, (m_acc >> (W - 1)) & 1, hold);
  endtask

  initial begin
    int accepts;
    int last_acc;
    int prev;
    bit seen;
    logic [1:0] rop;

    bus.in_valid = 1'b0;
    bus.in_op = 2'b00;
    bus.in_b = '0;
    bus.out_ready = 1'b0;
    model_reset();

    tbl[0] = '{OP_LOAD, 5, 0, 5, 0, 0, 0, 0};
    tbl[1] = '{OP_ADD,  3, 2, 8, 0, 1, 0, 1};
    tbl[2] = '{OP_LOAD, 3, 0, 3, 0, 0, 0, 0};
    tbl[3] = '{OP_SUB,  3, 1, 0, 1, 0, 1, 0};
    tbl[4] = '{OP_LOAD, 2, 0, 2, 0, 0, 0, 0};
    tbl[5] = '{OP_SUB,  5, 3, 13, 0, 0, 0, 1};
    tbl[6] = '{OP_LOAD, 8, 0, 8, 0, 0, 0, 1};
    tbl[7] = '{OP_SUB,  1, 0, 7, 1, 1, 0, 0};
    tbl[8] = '{OP_ADD,  9, 1, 0, 1, 0, 1, 0};
    tbl[9] = '{OP_CLR, 11, 0, 0, 0, 0, 1, 0};
`ifdef ADDSUB_ACC_SAT_EN
    tbl[1] = '{OP_ADD,  3, 2, 7, 0, 1, 0, 0};
    tbl[7] = '{OP_SUB,  1, 0, 8, 1, 1, 0, 1};
    tbl[8] = '{OP_ADD,  9, 1, 8, 1, 1, 0, 1};
`endif

    // Reset state, asserted and after release.
    #12;
    chk("rst_acc", int'(bus.acc), 0);
    chk("rst_z", int'(bus.flag_z), 1);
    chk("rst_cvn", int'({bus.flag_c, bus.flag_v, bus.flag_n}), 0);
    chk("rst_ovalid", int'(bus.out_valid), 0);
    chk("rst_iready", int'(bus.in_ready), 1);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_acc", int'(bus.acc), 0);
    chk("idle_z", int'(bus.flag_z), 1);
    chk("idle_ovalid", int'(bus.out_valid), 0);
    chk("idle_iready", int'(bus.in_ready), 1);

    for (int i = 0; i < 10; i++) begin
      issue(tbl[i].op, tbl[i].b);
      expect_result($sformatf("vec%0d", i), tbl[i].eacc, tbl[i].ec, tbl[i].ev,
                    tbl[i].ez, tbl[i].en, tbl[i].hold);
      chk($sformatf("vec%0d_model", i), m_acc, tbl[i].eacc);
    end

    // Backpressure with a second command waiting.
    issue(OP_LOAD, 9);
    @(negedge clk);
    @(negedge clk);
    chk("bp_first_ovalid", int'(bus.out_valid), 1);
    bus.in_valid = 1'b1;
    bus.in_op = OP_SUB;
    bus.in_b = 4'd2;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_ovalid", int'(bus.out_valid), 1);
      chk("bp_acc", int'(bus.acc), 9);
      chk("bp_iready", int'(bus.in_ready), 0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    issue(OP_SUB, 2);
    expect_model("bp_second", 0);
    chk("bp_second_acc", int'(bus.acc), 7);

    // Back-to-back ADD 1 from 0xF with out_ready tied high.
    issue(OP_LOAD, 15);
    expect_model("b2b_load", 0);
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_op = OP_ADD;
    bus.in_b = 4'd1;
    accepts = 0;
    prev = -1;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 14) begin
        bus.in_valid = 1'b0;
      end else if (bus.in_ready) begin
        if (prev >= 0) chk("b2b_spacing", i - prev, 3);
        prev = i;
        accepts++;
      end
      if (bus.out_valid && !seen) begin
        seen = 1'b1;
        chk("b2b_wrap_acc", int'(bus.acc), 0);
        chk("b2b_wrap_c", int'(bus.flag_c), 1);
        chk("b2b_wrap_z", int'(bus.flag_z), 1);
      end
    end
    chk("b2b_seen", int'(seen), 1);
    chk("b2b_accepts", accepts, 5);
    repeat (2) @(negedge clk);
    bus.out_ready = 1'b0;
    for (int i = 0; i < accepts; i++) model_apply(OP_ADD, 1);
    chk("b2b_final_acc", int'(bus.acc), m_acc);
    chk("b2b_final_iready", int'(bus.in_ready), 1);

    // Reset during CALC of ADD 4 with acc=2.
    issue(OP_LOAD, 2);
    expect_model("mid_load", 0);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_op = OP_ADD;
    bus.in_b = 4'd4;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_acc", int'(bus.acc), 0);
    chk("mid_rst_z", int'(bus.flag_z), 1);
    chk("mid_rst_ovalid", int'(bus.out_valid), 0);
    chk("mid_rst_iready", int'(bus.in_ready), 1);
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mid_no_pulse", int'(bus.out_valid), 0);
      chk("mid_acc_hold", int'(bus.acc), 0);
    end
    issue(OP_LOAD, 1);
    expect_model("mid_reload", 0);
    chk("mid_reload_acc", int'(bus.acc), 1);

    // Randomized commands against the arithmetic model.
    for (int i = 0; i < 150; i++) begin
      rop = 2'($urandom_range(0, 3));
      if (rop == 2'b00 && $urandom_range(0, 3) != 0) rop = 2'b10;
      issue(rop, int'($urandom_range(0, MASK)));
      expect_model($sformatf("rnd%0d", i), int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
